// File: rtl/rf_freq_meter.sv
// Gated edge counter for an asynchronous RF/carrier input, measured against CLK1.
// Reports a saturating rising-edge count per window plus a hysteretic carrier flag.
module rf_freq_meter #(
  parameter int GATE_CYCLES = 12000,
  parameter int CNT_W       = 16,
  parameter int THRESH_ON   = 100,
  parameter int THRESH_OFF  = 50
) (
  input  logic             CLK1,
  input  logic             RST,
  input  logic             rf_in,
  input  logic             enable,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             freq_ovf,
  output logic             carrier
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             s1_reg, s2_reg, s3_reg;
  logic             edge_det;
  logic [GW-1:0]    gate_reg, gate_next;
  logic [CNT_W-1:0] edge_cnt_reg, edge_cnt_next;
  logic             sat_reg, sat_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             valid_reg, valid_next;
  logic             ovf_reg, ovf_next;
  logic             carrier_reg, carrier_next;
  logic             close_win;
  logic             step_sat;
  logic [CNT_W-1:0] step_cnt;

  assign edge_det  = s2_reg & ~s3_reg;
  assign close_win = enable && (gate_reg == GATE_LAST);

  // Saturating edge_cnt + edge; shared by mid-window accumulation and the close-cycle result.
  always_comb begin
    step_sat = edge_det && (edge_cnt_reg == CNT_MAX);
    step_cnt = step_sat ? CNT_MAX : edge_cnt_reg + CNT_W'(edge_det);
  end

  always_comb begin
    gate_next     = gate_reg;
    edge_cnt_next = edge_cnt_reg;
    sat_next      = sat_reg;
    count_next    = count_reg;
    ovf_next      = ovf_reg;
    carrier_next  = carrier_reg;
    valid_next    = 1'b0;
    if (!enable) begin
      gate_next     = '0;
      edge_cnt_next = '0;
      sat_next      = 1'b0;
    end else if (close_win) begin
      gate_next     = '0;
      edge_cnt_next = '0;
      sat_next      = 1'b0;
      count_next    = step_cnt;
      ovf_next      = sat_reg | step_sat;
      valid_next    = 1'b1;
      if (int'(step_cnt) >= THRESH_ON)
        carrier_next = 1'b1;
      else if (int'(step_cnt) < THRESH_OFF)
        carrier_next = 1'b0;
    end else begin
      gate_next     = gate_reg + GW'(1);
      edge_cnt_next = step_cnt;
      sat_next      = sat_reg | step_sat;
    end
  end

  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      s3_reg       <= 1'b0;
      gate_reg     <= '0;
      edge_cnt_reg <= '0;
      sat_reg      <= 1'b0;
      count_reg    <= '0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      carrier_reg  <= 1'b0;
    end else begin
      s1_reg       <= rf_in;
      s2_reg       <= s1_reg;
      s3_reg       <= s2_reg;
      gate_reg     <= gate_next;
      edge_cnt_reg <= edge_cnt_next;
      sat_reg      <= sat_next;
      count_reg    <= count_next;
      valid_reg    <= valid_next;
      ovf_reg      <= ovf_next;
      carrier_reg  <= carrier_next;
    end
  end

  assign freq_count = count_reg;
  assign freq_valid = valid_reg;
  assign freq_ovf   = ovf_reg;
  assign carrier    = carrier_reg;

endmodule

// File: tb/tb_rf_freq_meter.sv
// Bench for rf_freq_meter: an 8-bit and a 4-bit instance share stimulus and are
// compared every cycle against a sample-history window model, plus directed tables.
module tb_rf_freq_meter;

  localparam int GATE = 100;
  localparam int TON  = 20;
  localparam int TOFF = 10;

  logic       CLK1 = 1'b0;
  logic       RST;
  logic       rf_in;
  logic       enable;
  logic [7:0] fc8;
  logic       fv8, fo8, car8;
  logic [3:0] fc4;
  logic       fv4, fo4, car4;

  always #5 CLK1 = ~CLK1;

  rf_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(8), .THRESH_ON(TON), .THRESH_OFF(TOFF)) dut8 (
    .CLK1(CLK1), .RST(RST), .rf_in(rf_in), .enable(enable),
    .freq_count(fc8), .freq_valid(fv8), .freq_ovf(fo8), .carrier(car8)
  );

  rf_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4), .THRESH_ON(TON), .THRESH_OFF(TOFF)) dut4 (
    .CLK1(CLK1), .RST(RST), .rf_in(rf_in), .enable(enable),
    .freq_count(fc4), .freq_valid(fv4), .freq_ovf(fo4), .carrier(car4)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: an edge is counted two samples after rf_in is first seen high.
  bit samp[$];
  int m_k, m_total, m_sz;
  bit m_edge;
  int e_count8, e_count4;
  bit e_valid, e_ovf8, e_ovf4, e_car8, e_car4;

  function automatic bit hyst(input bit prev, input int c);
    if (c >= TON) return 1'b1;
    if (c < TOFF) return 1'b0;
    return prev;
  endfunction

  always @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      samp.delete();
      m_k = 0; m_total = 0;
      e_valid = 0; e_count8 = 0; e_count4 = 0;
      e_ovf8 = 0; e_ovf4 = 0; e_car8 = 0; e_car4 = 0;
    end else begin
      samp.push_back(rf_in);
      if (samp.size() > 4) samp.delete(0);
      m_sz = samp.size();
      m_edge = 0;
      if (m_sz >= 3) begin
        m_edge = samp[m_sz-3];
        if (m_sz >= 4) m_edge = m_edge && !samp[m_sz-4];
      end
      e_valid = 0;
      if (!enable) begin
        m_k = 0; m_total = 0;
      end else begin
        m_total += int'(m_edge);
        m_k++;
        if (m_k == GATE) begin
          e_valid  = 1;
          e_count8 = (m_total > 255) ? 255 : m_total;
          e_ovf8   = (m_total > 255);
          e_count4 = (m_total > 15) ? 15 : m_total;
          e_ovf4   = (m_total > 15);
          e_car8   = hyst(e_car8, e_count8);
          e_car4   = hyst(e_car4, e_count4);
          m_k = 0; m_total = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input logic [31:0] actual, input int lo, input int hi);
    checks++;
    if ($isunknown(actual) || int'(actual) < lo || int'(actual) > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Stimulus generator: 0 = manual rf_in, 1 = square wave, 2 = random noise.
  int gen_mode, per, ph;
  bit mon_en;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK1);
      if (mon_en) begin
        check("mdl_valid8", fv8, e_valid);
        check("mdl_count8", fc8, e_count8);
        check("mdl_ovf8", fo8, e_ovf8);
        check("mdl_car8", car8, e_car8);
        check("mdl_valid4", fv4, e_valid);
        check("mdl_count4", fc4, e_count4);
        check("mdl_ovf4", fo4, e_ovf4);
        check("mdl_car4", car4, e_car4);
      end
      if (gen_mode == 1) begin
        rf_in = (ph < per / 2);
        ph = (ph + 1) % per;
      end else if (gen_mode == 2) begin
        rf_in = $urandom_range(0, 1) != 0;
      end
    end
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (fv8 !== 1'b1 && n < 250);
    check(name, fv8, 1);
  endtask

  task automatic set_wave(input int period);
    if (period == 0) begin gen_mode = 0; rf_in = 1'b0; end
    else if (period == 1) begin gen_mode = 0; rf_in = 1'b1; end
    else begin gen_mode = 1; per = period; ph = 0; end
  endtask

  typedef struct {
    int period;
    int lo, hi;
    bit car;
    int lo4, hi4;
    bit ovf4;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int n;
    vecs[0] = '{4,  25, 25, 1, 15, 15, 1};
    vecs[1] = '{8,  12, 13, 1, 12, 13, 0};
    vecs[2] = '{20,  5,  5, 0,  5,  5, 0};
    vecs[3] = '{8,  12, 13, 0, 12, 13, 0};
    vecs[4] = '{4,  25, 25, 1, 15, 15, 1};
    vecs[5] = '{1,   0,  0, 0,  0,  0, 0};
    vecs[6] = '{4,  25, 25, 1, 15, 15, 1};
    vecs[7] = '{0,   0,  0, 0,  0,  0, 0};

    RST = 1'b1; enable = 1'b1; rf_in = 1'b0; mon_en = 1'b1;
    gen_mode = 1; per = 2; ph = 0;

    // Reset held with rf toggling, then idle input for three windows
    step(20);
    check("rst_count", fc8, 0);
    check("rst_valid", fv8, 0);
    check("rst_carrier", car8, 0);
    set_wave(0);
    RST = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      step(1);
      check("idle_valid_pos", fv8, (i % 100 == 0) ? 1 : 0);
      if (i % 100 == 0) begin
        check("idle_count", fc8, 0);
        check("idle_carrier", car8, 0);
      end
    end

    // Table: two windows per entry; the second window is the settled one
    foreach (vecs[v]) begin
      set_wave(vecs[v].period);
      wait_valid("tbl_first_valid", n);
      wait_valid("tbl_second_valid", n);
      check("tbl_spacing", n, GATE);
      check_range("tbl_count8", fc8, vecs[v].lo, vecs[v].hi);
      check("tbl_carrier8", car8, vecs[v].car);
      check("tbl_ovf8", fo8, 0);
      check_range("tbl_count4", fc4, vecs[v].lo4, vecs[v].hi4);
      check("tbl_ovf4", fo4, vecs[v].ovf4);
    end

    // Abort a window by dropping enable at gate_cnt=50
    set_wave(4);
    wait_valid("abort_align1", n);
    wait_valid("abort_align2", n);
    step(50);
    enable = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      check("abort_no_valid", fv8, 0);
    end
    check("abort_hold_count", fc8, 25);
    check("abort_hold_car", car8, 1);
    check("abort_hold_ovf4", fo4, 1);
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 99; i++) begin
      step(1);
      if (fv8 !== 1'b0) n++;
    end
    check("reen_early_valids", n, 0);
    step(1);
    check("reen_valid", fv8, 1);
    check("reen_count", fc8, 25);

    // Edge strobe landing in the close cycle belongs to the closing window
    set_wave(0);
    wait_valid("close_align1", n);
    wait_valid("close_align2", n);
    step(97);
    rf_in = 1'b1;
    step(3);
    check("close_edge_valid", fv8, 1);
    check("close_edge_count", fc8, 1);
    step(100);
    check("close_next_valid", fv8, 1);
    check("close_next_count", fc8, 0);
    rf_in = 1'b0;
    wait_valid("late_align", n);
    step(98);
    rf_in = 1'b1;
    step(2);
    check("late_edge_valid", fv8, 1);
    check("late_edge_count", fc8, 0);
    step(100);
    check("late_next_valid", fv8, 1);
    check("late_next_count", fc8, 1);

    // Asynchronous reset between clock edges, mid-window
    set_wave(4);
    wait_valid("arst_align1", n);
    wait_valid("arst_align2", n);
    check("arst_pre_count", fc8, 25);
    step(37);
    #2;
    RST = 1'b1;
    #1;
    check("arst_count8", fc8, 0);
    check("arst_car8", car8, 0);
    check("arst_count4", fc4, 0);
    check("arst_ovf4", fo4, 0);
    check("arst_valid", fv8, 0);
    step(5);
    RST = 1'b0;
    wait_valid("arst_first_valid", n);
    check("arst_first_latency", n, GATE);
    check("arst_first_count", fc8, 25);

    // Randomized segments checked continuously against the model
    for (int seg = 0; seg < 24; seg++) begin
      if ($urandom_range(0, 9) < 7) begin
        gen_mode = 1;
        per = $urandom_range(2, 30);
        ph = $urandom_range(0, per - 1);
      end else begin
        gen_mode = 2;
      end
      if ($urandom_range(0, 9) < 3) begin
        step($urandom_range(10, 150));
        enable = 1'b0;
        step($urandom_range(1, 40));
        enable = 1'b1;
      end
      step($urandom_range(50, 250));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
